// File: rtl/ps2_pkg.sv
// Shared PS/2 constants: scancodes, ASCII values, held-bit positions,
// prefix FSM states and the queued event record.
package ps2_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [7:0] ASCII_W = 8'd87;
  localparam logic [7:0] ASCII_A = 8'd65;
  localparam logic [7:0] ASCII_S = 8'd83;
  localparam logic [7:0] ASCII_D = 8'd68;

  // Bit positions inside held, MSB first: {W,A,S,D,up,down,left,right}
  localparam logic [2:0] HELD_W     = 3'd7;
  localparam logic [2:0] HELD_A     = 3'd6;
  localparam logic [2:0] HELD_S     = 3'd5;
  localparam logic [2:0] HELD_D     = 3'd4;
  localparam logic [2:0] HELD_UP    = 3'd3;
  localparam logic [2:0] HELD_DOWN  = 3'd2;
  localparam logic [2:0] HELD_LEFT  = 3'd1;
  localparam logic [2:0] HELD_RIGHT = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXT       = 2'd1,
    ST_BREAK     = 2'd2,
    ST_EXT_BREAK = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       rel;
    logic       ext;
  } evt_t;

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// Scancode input strobe and event-queue handshake bundle between a
// scancode producer / event consumer (master) and the sequencer (slave).
interface ps2_key_sequencer_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       evt_ready;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic       evt_release;
  logic       evt_ext;

  modport master (
    output scan_code, scan_valid, evt_ready,
    input  evt_valid, evt_data, evt_release, evt_ext
  );

  modport slave (
    input  scan_code, scan_valid, evt_ready,
    output evt_valid, evt_data, evt_release, evt_ext
  );
endinterface

// File: rtl/ps2_key_sequencer_scancode_map.sv
// Combinational final-code lookup: ASCII for WASD, arrows keep their code;
// mapped flags keys that own a held bit.
module scancode_map
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  output logic [7:0] data,
  output logic       mapped,
  output logic [2:0] held_idx
);
  always_comb begin
    data     = code;
    mapped   = 1'b1;
    held_idx = '0;
    case (code)
      SC_W:     begin data = ASCII_W; held_idx = HELD_W; end
      SC_A:     begin data = ASCII_A; held_idx = HELD_A; end
      SC_S:     begin data = ASCII_S; held_idx = HELD_S; end
      SC_D:     begin data = ASCII_D; held_idx = HELD_D; end
      SC_UP:    held_idx = HELD_UP;
      SC_DOWN:  held_idx = HELD_DOWN;
      SC_LEFT:  held_idx = HELD_LEFT;
      SC_RIGHT: held_idx = HELD_RIGHT;
      default:  mapped = 1'b0;
    endcase
  end
endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 scancode sequencer: prefix decoding, held-key tracking with
// typematic suppression, and a small event queue with sticky overflow.
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       evt_ready,
  input  logic       ovf_clr,
  output logic       evt_valid,
  output logic [7:0] evt_data,
  output logic       evt_release,
  output logic       evt_ext,
  output logic [7:0] held,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  state_t state_reg, state_next;
  logic   final_code, code_rel, code_ext;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    final_code = 1'b0;
    code_rel   = (state_reg == ST_BREAK) || (state_reg == ST_EXT_BREAK);
    code_ext   = (state_reg == ST_EXT)   || (state_reg == ST_EXT_BREAK);
    if (scan_valid) begin
      if (scan_code == SC_E0) begin
        state_next = ST_EXT;
      end else if (scan_code == SC_F0) begin
        case (state_reg)
          ST_IDLE: state_next = ST_BREAK;
          ST_EXT:  state_next = ST_EXT_BREAK;
          default: state_next = state_reg;
        endcase
      end else begin
        state_next = ST_IDLE;
        final_code = 1'b1;
      end
    end
  end

  logic [7:0] map_data;
  logic       map_hit;
  logic [2:0] map_idx;

  scancode_map u_map (
    .code     (scan_code),
    .data     (map_data),
    .mapped   (map_hit),
    .held_idx (map_idx)
  );

  logic [7:0] held_reg, held_next;
  logic       push, suppress;

  // A make of a key already held is a typematic repeat: no event, no change
  assign suppress = map_hit && !code_rel && held_reg[map_idx];
  assign push     = final_code && !suppress;

  for (genvar gi = 0; gi < 8; gi++) begin : g_held
    assign held_next[gi] = (final_code && map_hit && map_idx == 3'(gi)) ? !code_rel
                                                                        : held_reg[gi];
  end

  evt_t          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          overflow_reg, overflow_next;
  logic          fifo_full, pop, wr_en, drop;

  assign fifo_full = (count_reg == CW'(FIFO_DEPTH));
  assign pop       = (count_reg != '0) && evt_ready;
  assign wr_en     = push && (!fifo_full || pop);
  assign drop      = push && fifo_full && !pop;

  always_comb begin
    count_next = count_reg;
    case ({wr_en, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    overflow_next = overflow_reg;
    if (drop)         overflow_next = 1'b1;
    else if (ovf_clr) overflow_next = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (wr_en) fifo_mem[wr_ptr_reg] <= '{data: map_data, rel: code_rel, ext: code_ext};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      held_reg     <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      held_reg     <= held_next;
    end
  end

  // Head fields are forced to zero while empty so reset drives clean outputs
  evt_t head;
  assign head        = fifo_mem[rd_ptr_reg];
  assign evt_valid   = (count_reg != '0);
  assign evt_data    = evt_valid ? head.data : 8'h00;
  assign evt_release = evt_valid & head.rel;
  assign evt_ext     = evt_valid & head.ext;
  assign held        = held_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed and randomized bench for ps2_key_sequencer against a queue-based
// reference model of the prefix/held/queue rules.
module tb_ps2_key_sequencer;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] held;
  logic       overflow;

  ps2_key_sequencer_if bus ();

  ps2_key_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .scan_code   (bus.scan_code),
    .scan_valid  (bus.scan_valid),
    .evt_ready   (bus.evt_ready),
    .ovf_clr     (ovf_clr),
    .evt_valid   (bus.evt_valid),
    .evt_data    (bus.evt_data),
    .evt_release (bus.evt_release),
    .evt_ext     (bus.evt_ext),
    .held        (held),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  // Reference state: pending prefix flags, held keys, event queue {data,rel,ext}
  logic [9:0] mq[$];
  bit   [7:0] m_held;
  bit         m_ovf, m_ext, m_rel;
  int         n_pass = 0;
  int         n_checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void ref_map(input logic [7:0] c, output logic [7:0] d,
                                  output bit hit, output int idx);
    hit = 1'b1; d = c; idx = 0;
    case (c)
      8'h1D:   begin d = 8'd87; idx = 7; end
      8'h1C:   begin d = 8'd65; idx = 6; end
      8'h1B:   begin d = 8'd83; idx = 5; end
      8'h23:   begin d = 8'd68; idx = 4; end
      8'h75:   idx = 3;
      8'h72:   idx = 2;
      8'h6B:   idx = 1;
      8'h74:   idx = 0;
      default: hit = 1'b0;
    endcase
  endfunction

  function automatic void model_step(input bit sv, input logic [7:0] code,
                                     input bit rdy, input bit clr);
    bit         do_push = 1'b0;
    bit         hit, drop;
    logic [7:0] d;
    logic [9:0] ev = '0;
    int         idx;
    bit         pop = (mq.size() > 0) && rdy;
    if (sv) begin
      if (code == 8'hE0) begin
        m_ext = 1'b1; m_rel = 1'b0;
      end else if (code == 8'hF0) begin
        m_rel = 1'b1;
      end else begin
        ref_map(code, d, hit, idx);
        do_push = 1'b1;
        if (hit) begin
          if (m_rel)            m_held[idx] = 1'b0;
          else if (m_held[idx]) do_push = 1'b0;
          else                  m_held[idx] = 1'b1;
        end
        ev = {d, m_rel, m_ext};
        m_ext = 1'b0; m_rel = 1'b0;
      end
    end
    drop = 1'b0;
    if (pop) begin
      $display("pop  data=%02h rel=%0d ext=%0d", mq[0][9:2], mq[0][1], mq[0][0]);
      void'(mq.pop_front());
    end
    if (do_push) begin
      if (mq.size() < DEPTH) mq.push_back(ev);
      else drop = 1'b1;
    end
    if (drop)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endfunction

  task automatic cycle(input bit sv, input logic [7:0] code, input bit rdy, input bit clr);
    bus.scan_valid = sv; bus.scan_code = code; bus.evt_ready = rdy; ovf_clr = clr;
    model_step(sv, code, rdy, clr);
    @(posedge clock); #1;
    chk("evt_valid", bus.evt_valid, mq.size() != 0);
    if (mq.size() != 0)
      chk("evt_head", {bus.evt_data, bus.evt_release, bus.evt_ext}, mq[0]);
    chk("held", held, m_held);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic do_reset();
    #2 resetn = 1'b0;
    #1;
    chk("rst_valid", bus.evt_valid, 0);
    chk("rst_data", bus.evt_data, 0);
    chk("rst_rel_ext", {bus.evt_release, bus.evt_ext}, 0);
    chk("rst_held", held, 0);
    chk("rst_ovf", overflow, 0);
    mq.delete(); m_held = '0; m_ovf = 1'b0; m_ext = 1'b0; m_rel = 1'b0;
    bus.scan_valid = 1'b0; bus.scan_code = '0; bus.evt_ready = 1'b0; ovf_clr = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
  endtask

  logic [7:0] pool [16] = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h1D, 8'h1C, 8'h1B, 8'h23,
                            8'h75, 8'h72, 8'h6B, 8'h74, 8'h15, 8'h16, 8'h2E, 8'h5A};
  logic [7:0] unm [6] = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};

  initial begin
    bus.scan_valid = 1'b0; bus.scan_code = '0; bus.evt_ready = 1'b0;
    @(posedge clock); #1;
    do_reset();

    // W make then break with consumer ready
    cycle(1, 8'h1D, 1, 0);
    chk("w_make", {bus.evt_data, bus.evt_release, bus.evt_ext}, {8'd87, 2'b00});
    chk("w_held_set", held[7], 1);
    cycle(1, 8'hF0, 1, 0);
    cycle(1, 8'h1D, 1, 0);
    chk("w_break", {bus.evt_data, bus.evt_release, bus.evt_ext}, {8'd87, 2'b10});
    chk("w_held_clr", held[7], 0);
    cycle(0, 8'h00, 1, 0);

    // Extended up arrow make/break
    cycle(1, 8'hE0, 1, 0); cycle(1, 8'h75, 1, 0);
    chk("up_make", {bus.evt_data, bus.evt_release, bus.evt_ext}, {8'h75, 2'b01});
    chk("up_held_set", held[3], 1);
    cycle(1, 8'hE0, 1, 0); cycle(1, 8'hF0, 1, 0); cycle(1, 8'h75, 1, 0);
    chk("up_break", {bus.evt_data, bus.evt_release, bus.evt_ext}, {8'h75, 2'b11});
    chk("up_held_clr", held[3], 0);
    cycle(0, 8'h00, 1, 0);

    // Typematic A: exactly two events queued
    cycle(1, 8'h1C, 0, 0); cycle(1, 8'h1C, 0, 0); cycle(1, 8'h1C, 0, 0);
    cycle(1, 8'hF0, 0, 0); cycle(1, 8'h1C, 0, 0);
    chk("typ_depth", dut.count_reg, 2);
    chk("typ_first", {bus.evt_data, bus.evt_release, bus.evt_ext}, {8'd65, 2'b00});
    cycle(0, 8'h00, 1, 0);
    chk("typ_second", {bus.evt_data, bus.evt_release, bus.evt_ext}, {8'd65, 2'b10});
    cycle(0, 8'h00, 1, 0);
    chk("typ_empty", bus.evt_valid, 0);

    // Overflow with six unmapped makes, then clear
    for (int i = 0; i < 6; i++) cycle(1, unm[i], 0, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", dut.count_reg, 4);
    chk("ovf_head", bus.evt_data, 8'h15);
    cycle(0, 8'h00, 0, 1);
    chk("ovf_clr", overflow, 0);

    // Push and pop together on a full queue
    cycle(1, 8'h4D, 1, 0);
    chk("full_pp_ovf", overflow, 0);
    chk("full_pp_count", dut.count_reg, 4);
    chk("full_pp_head", bus.evt_data, 8'h16);

    // Drop and clear in the same cycle: set wins
    cycle(1, 8'h4E, 0, 1);
    chk("ovf_set_prio", overflow, 1);

    // Reset mid-sequence discards the E0 F0 prefix
    cycle(1, 8'hE0, 0, 0); cycle(1, 8'hF0, 0, 0);
    do_reset();
    cycle(1, 8'h6B, 0, 0);
    chk("rst_seq_evt", {bus.evt_data, bus.evt_release, bus.evt_ext}, {8'h6B, 2'b00});
    chk("rst_seq_held", held[1], 1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cycle($urandom_range(0, 2) != 0, pool[$urandom_range(0, 15)],
            $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
